// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the mem_copy DMA master.
package mem_copy_pkg;

   localparam int unsigned ADDR_W     = 25;
   localparam int unsigned DATA_W     = 16;
   localparam int unsigned LEN_W      = 16;
   localparam int unsigned WORD_BYTES = 2;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ACQ   = 3'd1,
      S_WAITW = 3'd2,
      S_WRITE = 3'd3,
      S_READ  = 3'd4,
      S_GAP   = 3'd5,
      S_REL   = 3'd6
   } state_t;

   typedef enum logic {
      MODE_DL   = 1'b0,
      MODE_COPY = 1'b1
   } mode_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } word_t;

   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
      return a & ~ADDR_W'(1);
   endfunction

endpackage

// File: rtl/mem_copy_packer.sv
// Byte-to-word assembly for the host download stream, with end-of-file flush,
// a one-entry pending word buffer and a sticky overflow flag.
module mem_copy_packer
   import mem_copy_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_dl_active,
   input  logic              i_dl_wr,
   input  logic [ADDR_W-1:0] i_dl_addr,
   input  logic [7:0]        i_dl_data,
   input  logic [ADDR_W-1:0] i_dl_base,
   input  logic              i_pop,
   output logic              o_pend_valid,
   output word_t             o_pend_word,
   output logic              o_empty_c,
   output logic              o_dl_rise_c,
   output logic              o_overflow
);

   logic              r_dl_q;
   logic              r_lo_valid;
   logic [7:0]        r_lo;
   logic [ADDR_W-1:0] r_lo_addr;
   logic              r_pend_valid;
   word_t             r_pend_word;
   logic              r_overflow;

   logic              w_rise;
   logic              w_fall;
   logic [ADDR_W-1:0] w_wr_addr;
   logic              w_push;
   word_t             w_word;
   logic              w_full;

   assign w_rise    = i_dl_active & ~r_dl_q;
   assign w_fall    = ~i_dl_active & r_dl_q;
   assign w_wr_addr = word_align(i_dl_base) + word_align(i_dl_addr);
   // A pop in the same cycle frees the slot for an incoming word.
   assign w_full    = r_pend_valid & ~i_pop;

   always_comb begin
      w_push = 1'b0;
      w_word = '0;
      if (i_dl_wr && i_dl_addr[0]) begin
         w_push      = 1'b1;
         w_word.addr = w_wr_addr;
         w_word.data = {i_dl_data, (r_lo_valid ? r_lo : 8'h00)};
      end else if (w_fall && r_lo_valid) begin
         w_push      = 1'b1;
         w_word.addr = r_lo_addr;
         w_word.data = {8'h00, r_lo};
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_dl_q       <= 1'b0;
         r_lo_valid   <= 1'b0;
         r_lo         <= '0;
         r_lo_addr    <= '0;
         r_pend_valid <= 1'b0;
         r_pend_word  <= '0;
         r_overflow   <= 1'b0;
      end else begin
         r_dl_q <= i_dl_active;

         if (i_dl_wr && !i_dl_addr[0]) begin
            r_lo_valid <= 1'b1;
            r_lo       <= i_dl_data;
            r_lo_addr  <= w_wr_addr;
         end else if ((i_dl_wr && i_dl_addr[0]) || w_fall || w_rise) begin
            r_lo_valid <= 1'b0;
         end

         if (w_push && !w_full) begin
            r_pend_valid <= 1'b1;
            r_pend_word  <= w_word;
         end else if (i_pop) begin
            r_pend_valid <= 1'b0;
         end

         if (w_rise) begin
            r_overflow <= 1'b0;
         end else if (w_push && w_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign o_pend_valid = r_pend_valid;
   assign o_pend_word  = r_pend_word;
   assign o_empty_c    = ~r_lo_valid & ~r_pend_valid;
   assign o_dl_rise_c  = w_rise;
   assign o_overflow   = r_overflow;

endmodule

// File: rtl/mem_copy_dma.sv
// Upstream master for the memory block's mem_copy port: paces download words
// and word block copies into strobed accesses while owning mem_copy.
module mem_copy_dma
   import mem_copy_pkg::*;
#(
   parameter int unsigned WE_CYCLES     = 4,
   parameter int unsigned RD_LAT        = 6,
   parameter int unsigned GAP_CYCLES    = 1,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic              clk_bus,
   input  logic              reset,
   input  logic              dl_active,
   input  logic              dl_wr,
   input  logic [ADDR_W-1:0] dl_addr,
   input  logic [7:0]        dl_data,
   input  logic [ADDR_W-1:0] dl_base,
   input  logic              dl_virt,
   input  logic              cmd_start,
   input  logic [ADDR_W-1:0] cmd_src,
   input  logic [ADDR_W-1:0] cmd_dst,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              cmd_virt,
   output logic              mem_copy,
   output logic              mem_copy_virt,
   output logic [ADDR_W-1:0] mem_copy_addr,
   output logic [DATA_W-1:0] mem_copy_data_i,
   output logic              mem_copy_we,
   output logic              mem_copy_rd,
   input  logic [DATA_W-1:0] mem_copy_data_o,
   output logic              busy,
   output logic              done,
   output logic              overflow
);

   localparam int unsigned      TMR_W       = 8;
   localparam logic [TMR_W-1:0] WE_LAST     = TMR_W'(WE_CYCLES - 1);
   localparam logic [TMR_W-1:0] RD_LAST     = TMR_W'(RD_LAT - 1);
   localparam logic [TMR_W-1:0] GAP_LAST    = TMR_W'(GAP_CYCLES - 1);
   localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
   localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(WORD_BYTES);

   state_t            r_state, w_state_n;
   logic [TMR_W-1:0]  r_tmr, w_tmr_n;
   mode_t             r_mode, w_mode_n;
   logic              r_virt, w_virt_n;
   logic              r_dl_req, w_dl_req_n;
   logic [ADDR_W-1:0] r_src, w_src_n;
   logic [ADDR_W-1:0] r_dst, w_dst_n;
   logic [LEN_W-1:0]  r_len, w_len_n;
   logic [DATA_W-1:0] r_rdata, w_rdata_n;
   logic              r_after_rd, w_after_rd_n;
   logic [ADDR_W-1:0] r_addr, w_addr_n;
   logic [DATA_W-1:0] r_wdata, w_wdata_n;
   logic              r_done, w_done_n;
   logic              r_mem_copy, r_mem_copy_virt, r_we, r_rd, r_busy;

   logic              w_pop;
   logic              w_pend_valid;
   word_t             w_pend_word;
   logic              w_pk_empty;
   logic              w_dl_rise;
   logic              w_overflow;

   mem_copy_packer u_packer (
      .i_clk        (clk_bus),
      .i_rst        (reset),
      .i_dl_active  (dl_active),
      .i_dl_wr      (dl_wr),
      .i_dl_addr    (dl_addr),
      .i_dl_data    (dl_data),
      .i_dl_base    (dl_base),
      .i_pop        (w_pop),
      .o_pend_valid (w_pend_valid),
      .o_pend_word  (w_pend_word),
      .o_empty_c    (w_pk_empty),
      .o_dl_rise_c  (w_dl_rise),
      .o_overflow   (w_overflow)
   );

   // Next-state, datapath and strobe decisions.
   always_comb begin
      w_state_n    = r_state;
      w_mode_n     = r_mode;
      w_virt_n     = r_virt;
      w_dl_req_n   = r_dl_req;
      w_src_n      = r_src;
      w_dst_n      = r_dst;
      w_len_n      = r_len;
      w_rdata_n    = r_rdata;
      w_after_rd_n = r_after_rd;
      w_addr_n     = r_addr;
      w_wdata_n    = r_wdata;
      w_done_n     = 1'b0;
      w_pop        = 1'b0;

      // A download that starts during a copy is remembered until the copy ends.
      if (w_dl_rise && !(r_state != S_IDLE && r_mode == MODE_DL)) begin
         w_dl_req_n = 1'b1;
      end

      case (r_state)
         S_IDLE: begin
            if (w_dl_rise || r_dl_req) begin
               w_state_n  = S_ACQ;
               w_mode_n   = MODE_DL;
               w_virt_n   = dl_virt;
               w_dl_req_n = 1'b0;
            end else if (cmd_start) begin
               if (cmd_len == '0) begin
                  w_done_n = 1'b1;
               end else begin
                  w_state_n = S_ACQ;
                  w_mode_n  = MODE_COPY;
                  w_virt_n  = cmd_virt;
                  w_src_n   = word_align(cmd_src);
                  w_dst_n   = word_align(cmd_dst);
                  w_len_n   = cmd_len;
               end
            end
         end
         S_ACQ: begin
            if (r_tmr == SETTLE_LAST) begin
               if (r_mode == MODE_DL) begin
                  w_state_n = S_WAITW;
               end else begin
                  w_state_n = S_READ;
                  w_addr_n  = r_src;
               end
            end
         end
         S_WAITW: begin
            if (w_pend_valid) begin
               w_state_n = S_WRITE;
               w_pop     = 1'b1;
               w_addr_n  = w_pend_word.addr;
               w_wdata_n = w_pend_word.data;
            end else if (!dl_active && w_pk_empty) begin
               w_state_n = S_REL;
            end
         end
         S_WRITE: begin
            if (r_tmr == WE_LAST) begin
               w_state_n    = S_GAP;
               w_after_rd_n = 1'b0;
               if (r_mode == MODE_COPY) begin
                  w_len_n = r_len - LEN_W'(1);
                  w_src_n = r_src + STEP;
                  w_dst_n = r_dst + STEP;
               end
            end
         end
         S_READ: begin
            if (r_tmr == RD_LAST) begin
               w_state_n    = S_GAP;
               w_rdata_n    = mem_copy_data_o;
               w_after_rd_n = 1'b1;
            end
         end
         S_GAP: begin
            if (r_tmr == GAP_LAST) begin
               if (r_mode == MODE_DL) begin
                  w_state_n = S_WAITW;
               end else if (r_after_rd) begin
                  w_state_n = S_WRITE;
                  w_addr_n  = r_dst;
                  w_wdata_n = r_rdata;
               end else if (r_len != '0) begin
                  w_state_n = S_READ;
                  w_addr_n  = r_src;
               end else begin
                  w_state_n = S_REL;
               end
            end
         end
         S_REL: begin
            if (r_tmr == SETTLE_LAST) begin
               w_state_n = S_IDLE;
               w_done_n  = 1'b1;
            end
         end
         default: w_state_n = S_IDLE;
      endcase

      w_tmr_n = (w_state_n != r_state) ? '0 : r_tmr + TMR_W'(1);
   end

   always_ff @(posedge clk_bus or posedge reset) begin
      if (reset) begin
         r_state         <= S_IDLE;
         r_tmr           <= '0;
         r_mode          <= MODE_DL;
         r_virt          <= 1'b0;
         r_dl_req        <= 1'b0;
         r_src           <= '0;
         r_dst           <= '0;
         r_len           <= '0;
         r_rdata         <= '0;
         r_after_rd      <= 1'b0;
         r_addr          <= '0;
         r_wdata         <= '0;
         r_done          <= 1'b0;
         r_mem_copy      <= 1'b0;
         r_mem_copy_virt <= 1'b0;
         r_we            <= 1'b0;
         r_rd            <= 1'b0;
         r_busy          <= 1'b0;
      end else begin
         r_state         <= w_state_n;
         r_tmr           <= w_tmr_n;
         r_mode          <= w_mode_n;
         r_virt          <= w_virt_n;
         r_dl_req        <= w_dl_req_n;
         r_src           <= w_src_n;
         r_dst           <= w_dst_n;
         r_len           <= w_len_n;
         r_rdata         <= w_rdata_n;
         r_after_rd      <= w_after_rd_n;
         r_addr          <= w_addr_n;
         r_wdata         <= w_wdata_n;
         r_done          <= w_done_n;
         r_mem_copy      <= (w_state_n != S_IDLE);
         r_mem_copy_virt <= (w_state_n != S_IDLE) & w_virt_n;
         r_we            <= (w_state_n == S_WRITE);
         r_rd            <= (w_state_n == S_READ);
         r_busy          <= (w_state_n != S_IDLE);
      end
   end

   assign mem_copy        = r_mem_copy;
   assign mem_copy_virt   = r_mem_copy_virt;
   assign mem_copy_addr   = r_addr;
   assign mem_copy_data_i = r_wdata;
   assign mem_copy_we     = r_we;
   assign mem_copy_rd     = r_rd;
   assign busy            = r_busy;
   assign done            = r_done;
   assign overflow        = w_overflow;

endmodule
